uart_system: RTL and testbench

- Two identical UART endpoints (UART1, UART2) in one block, cross-wired internally: Tx_1 feeds UART2's receiver and Tx_2 feeds UART1's receiver.
- Each endpoint serializes an 8-bit byte into an 11-bit frame at one bit per clock.
- Each endpoint presents the last complete frame it received as an 11-bit word.
- Used as a self-contained loopback/link block for serial-link bring-up.

---
 rtl/uart_system.sv | 165 ++++++++++++++++
 tb/tb_uart_system.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_system.sv
// Two cross-wired UART endpoints: 11-bit frames (start, 8 data LSB first, parity, stop) at one bit per clock.
// Each receiver keeps the last frame whose stop bit was 1.
module uart_endpoint #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_n_i,
    input  logic [7:0]  data_i,
    input  logic        rx_line_i,
    output logic        tx_line_o,
    output logic [10:0] rx_word_o
);
    // tx: IDLE line high/arm | START | DATA 8 bits | PARITY | STOP ; rx: IDLE wait start | SHIFT bits 1..10
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

    tx_state_t   tx_state_q, tx_state_d;
    logic [7:0]  hold_q, hold_d;
    logic        par_q, par_d;
    logic        armed_q, armed_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic        tx_q, tx_bit;

    rx_state_t   rx_state_q, rx_state_d;
    logic [9:0]  sr_q, sr_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [10:0] rx_word_q;
    logic        rx_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            hold_q     <= 8'h00;
            par_q      <= 1'b0;
            armed_q    <= 1'b1;
            tx_cnt_q   <= 3'd0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            sr_q       <= 10'd0;
            rx_cnt_q   <= 4'd0;
            rx_word_q  <= 11'd0;
        end else begin
            tx_state_q <= tx_state_d;
            hold_q     <= hold_d;
            par_q      <= par_d;
            armed_q    <= armed_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_q       <= tx_bit;
            rx_state_q <= rx_state_d;
            sr_q       <= sr_d;
            rx_cnt_q   <= rx_cnt_d;
            if (rx_load) rx_word_q <= {rx_line_i, sr_q};
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        hold_d     = hold_q;
        par_d      = par_q;
        armed_d    = armed_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (req_n_i) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    hold_d     = data_i;
                    par_d      = (^data_i) ^ PARITY_ODD;
                    armed_d    = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_cnt_d   = 3'd7;
                tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                hold_d = {1'b0, hold_q[7:1]};
                if (tx_cnt_q == 3'd0) tx_state_d = TX_PARITY;
                else                  tx_cnt_d   = tx_cnt_q - 3'd1;
            end
            TX_PARITY: tx_state_d = TX_STOP;
            TX_STOP:   tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        case (tx_state_q)
            TX_START:  tx_bit = 1'b0;
            TX_DATA:   tx_bit = hold_q[0];
            TX_PARITY: tx_bit = par_q;
            default:   tx_bit = 1'b1;
        endcase
    end

    // Bits arrive LSB first, so shifting in from the top leaves bit 0 at sr_q[0].
    always_comb begin
        rx_state_d = rx_state_q;
        sr_d       = sr_q;
        rx_cnt_d   = rx_cnt_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line_i) begin
                    sr_d       = {rx_line_i, sr_q[9:1]};
                    rx_cnt_d   = 4'd9;
                    rx_state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (rx_cnt_q == 4'd0) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    sr_d     = {rx_line_i, sr_q[9:1]};
                    rx_cnt_d = rx_cnt_q - 4'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_load = (rx_state_q == RX_SHIFT) && (rx_cnt_q == 4'd0) && rx_line_i;
    end

    assign tx_line_o = tx_q;
    assign rx_word_o = rx_word_q;
endmodule

module uart_system #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        idle_uart1,
    input  logic        idle_uart2,
    input  logic [7:0]  dataIn_uart1,
    input  logic [7:0]  dataIn_uart2,
    output logic        Tx_1,
    output logic        Tx_2,
    output logic [10:0] Rx_1,
    output logic [10:0] Rx_2
);
    uart_endpoint #(.PARITY_ODD(PARITY_ODD)) u_uart1 (
        .clk       (clk),
        .reset     (reset),
        .req_n_i   (idle_uart1),
        .data_i    (dataIn_uart1),
        .rx_line_i (Tx_2),
        .tx_line_o (Tx_1),
        .rx_word_o (Rx_1)
    );

    uart_endpoint #(.PARITY_ODD(PARITY_ODD)) u_uart2 (
        .clk       (clk),
        .reset     (reset),
        .req_n_i   (idle_uart2),
        .data_i    (dataIn_uart2),
        .rx_line_i (Tx_1),
        .tx_line_o (Tx_2),
        .rx_word_o (Rx_2)
    );
endmodule

// File: tb/tb_uart_system.sv
// Self-checking bench for uart_system: table of directed frames, hand-written corner sequences, random traffic.
module tb_uart_system;
    localparam bit PODD = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        idle_uart1 = 1'b1;
    logic        idle_uart2 = 1'b1;
    logic [7:0]  dataIn_uart1 = 8'h00;
    logic [7:0]  dataIn_uart2 = 8'h00;
    logic        Tx_1, Tx_2;
    logic [10:0] Rx_1, Rx_2;

    int total = 0;
    int bad = 0;
    logic [10:0] m_rx1 = 11'd0;
    logic [10:0] m_rx2 = 11'd0;

    uart_system #(.PARITY_ODD(PODD)) dut (
        .clk          (clk),
        .reset        (reset),
        .idle_uart1   (idle_uart1),
        .idle_uart2   (idle_uart2),
        .dataIn_uart1 (dataIn_uart1),
        .dataIn_uart2 (dataIn_uart2),
        .Tx_1         (Tx_1),
        .Tx_2         (Tx_2),
        .Rx_1         (Rx_1),
        .Rx_2         (Rx_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r1;
        bit         r2;
        logic [7:0] d1;
        logic [7:0] d2;
        bit         scramble;
        logic [10:0] exp_rx1;
        logic [10:0] exp_rx2;
    } vec_t;

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as it appears on the wire and in Rx: {stop, parity, data, start}.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) == 1) ? ~PODD : PODD;
        return {1'b1, p, d, 1'b0};
    endfunction

    // Request low at edge N, held for 'hold' edges; checks lines and Rx after edges N..N+19.
    task automatic run_frame(input bit r1, input bit r2, input logic [7:0] d1, input logic [7:0] d2,
                             input int hold, input bit scramble);
        logic [10:0] f1, f2, n1, n2, e1, e2;
        f1 = model_frame(d1);
        f2 = model_frame(d2);
        n1 = r2 ? f2 : m_rx1;
        n2 = r1 ? f1 : m_rx2;
        dataIn_uart1 = d1;
        dataIn_uart2 = d2;
        idle_uart1 = ~r1;
        idle_uart2 = ~r2;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            e1 = {10'd0, (r1 && k >= 1 && k <= 11) ? f1[k-1] : 1'b1};
            e2 = {10'd0, (r2 && k >= 1 && k <= 11) ? f2[k-1] : 1'b1};
            chk("tx1", {10'd0, Tx_1}, e1);
            chk("tx2", {10'd0, Tx_2}, e2);
            chk("rx1", Rx_1, (k >= 12) ? n1 : m_rx1);
            chk("rx2", Rx_2, (k >= 12) ? n2 : m_rx2);
            if (k == hold - 1) begin
                idle_uart1 = 1'b1;
                idle_uart2 = 1'b1;
            end
            if (scramble) begin
                dataIn_uart1 = 8'($urandom);
                dataIn_uart2 = 8'($urandom);
            end
        end
        idle_uart1 = 1'b1;
        idle_uart2 = 1'b1;
        m_rx1 = n1;
        m_rx2 = n2;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h38, 8'h00, 1'b0, 11'h000, 11'h670};
        vecs[1] = '{1'b0, 1'b1, 8'h38, 8'h55, 1'b0, 11'h4AA, 11'h670};
        vecs[2] = '{1'b1, 1'b0, 8'hF0, 8'h0F, 1'b1, 11'h4AA, 11'h5E0};
        vecs[3] = '{1'b0, 1'b1, 8'hF0, 8'h0F, 1'b1, 11'h41E, 11'h5E0};
        vecs[4] = '{1'b1, 1'b1, 8'h38, 8'h55, 1'b0, 11'h4AA, 11'h670};

        repeat (3) @(negedge clk);
        chk("rst_tx1", {10'd0, Tx_1}, 11'd1);
        chk("rst_rx2", Rx_2, 11'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_tx1", {10'd0, Tx_1}, 11'd1);
            chk("idle_tx2", {10'd0, Tx_2}, 11'd1);
            chk("idle_rx1", Rx_1, 11'd0);
            chk("idle_rx2", Rx_2, 11'd0);
        end

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].r1, vecs[v].r2, vecs[v].d1, vecs[v].d2, 20, vecs[v].scramble);
            chk("vec_rx1", Rx_1, vecs[v].exp_rx1);
            chk("vec_rx2", Rx_2, vecs[v].exp_rx2);
        end

        // Earliest relaunch: release before edge N+12, request again for edge N+13.
        dataIn_uart1 = 8'h5A;
        idle_uart1 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 12) chk("rearm_rx2", Rx_2, model_frame(8'h5A));
            if (k == 13) chk("rearm_idle", {10'd0, Tx_1}, 11'd1);
            if (k == 14) chk("rearm_start", {10'd0, Tx_1}, 11'd0);
            if (k == 1) idle_uart1 = 1'b1;
            if (k == 12) begin
                idle_uart1 = 1'b0;
                dataIn_uart1 = 8'hC3;
            end
        end
        idle_uart1 = 1'b1;
        repeat (12) @(negedge clk);
        chk("rearm_rx2b", Rx_2, model_frame(8'hC3));
        m_rx2 = model_frame(8'hC3);

        // Reset during DATA aborts the frame and clears Rx.
        dataIn_uart1 = 8'hA5;
        idle_uart1 = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("midrst_tx1", {10'd0, Tx_1}, 11'd1);
        chk("midrst_rx1", Rx_1, 11'd0);
        chk("midrst_rx2", Rx_2, 11'd0);
        idle_uart1 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_rx1 = 11'd0;
        m_rx2 = 11'd0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("postrst_tx1", {10'd0, Tx_1}, 11'd1);
            chk("postrst_rx2", Rx_2, 11'd0);
        end
        run_frame(1'b1, 1'b0, 8'h38, 8'h00, 3, 1'b0);
        chk("postrst_frame", Rx_2, 11'h670);

        for (int it = 0; it < 30; it++) begin
            bit r1, r2;
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            if (!r1 && !r2) r1 = 1'b1;
            run_frame(r1, r2, 8'($urandom), 8'($urandom), int'($urandom_range(1, 20)),
                      1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
